backtrack_ctrl: RTL

//  Trail-stack controller that sequences chronological backtracking for the BCP unit.

---
 rtl/backtrack_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/backtrack_ctrl.sv
// Trail-stack controller for chronological backtracking: records assignments, pops
// entries above a target level, then issues a forced flip. Optional: BT_STATS_EN.
module backtrack_ctrl #(
  parameter int VAR_NUM     = 8,
  parameter int VAR_NUM_LOG = 3,
  parameter int LVL_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [VAR_NUM_LOG-1:0] push_var,
  input  logic                   push_val,
  input  logic                   push_dec,
  input  logic                   bt_req,
  input  logic [LVL_W-1:0]       bt_level,
  output logic                   bt_busy,
  output logic                   bt_done,
  output logic                   unassign_valid,
  output logic [VAR_NUM_LOG-1:0] unassign_var,
  output logic                   flip_valid,
  output logic [VAR_NUM_LOG-1:0] flip_var,
  output logic                   flip_val,
  output logic [LVL_W-1:0]       cur_level,
  output logic [LVL_W-1:0]       trail_cnt,
  output logic                   full,
  output logic                   empty
`ifdef BT_STATS_EN
  ,
  output logic [15:0]            bt_count
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_POP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state;
  logic [LVL_W-1:0]       lvl_q;
  logic                   cand_valid;
  logic [VAR_NUM_LOG-1:0] cand_var;
  logic                   cand_val;

  logic [VAR_NUM_LOG-1:0] t_var [VAR_NUM];
  logic                   t_val [VAR_NUM];
  logic [LVL_W-1:0]       t_lvl [VAR_NUM];
  logic                   t_dec [VAR_NUM];

  logic [VAR_NUM_LOG-1:0] wr_idx;
  logic [VAR_NUM_LOG-1:0] top_idx;
  logic                   pop_hit;
  logic                   push_fire;
  logic [LVL_W-1:0]       push_lvl;

  assign empty   = (trail_cnt == '0);
  assign full    = (trail_cnt == LVL_W'(VAR_NUM));
  assign wr_idx  = trail_cnt[VAR_NUM_LOG-1:0];
  assign top_idx = wr_idx - VAR_NUM_LOG'(1);

  // Gated by rst so the handshake stays closed while reset is held.
  assign push_ready = rst && (state == S_IDLE) && !full && !bt_req;
  assign push_fire  = push_valid && push_ready;
  assign push_lvl   = push_dec ? cur_level + LVL_W'(1) : cur_level;

  assign pop_hit = (state == S_POP) && !empty && (t_lvl[top_idx] > lvl_q);

  assign bt_busy        = (state == S_POP);
  assign bt_done        = (state == S_DONE);
  assign unassign_valid = pop_hit;
  assign unassign_var   = pop_hit ? t_var[top_idx] : '0;
  assign flip_valid     = bt_done && cand_valid;
  assign flip_var       = flip_valid ? cand_var : '0;
  assign flip_val       = flip_valid && !cand_val;

  always_ff @(posedge clk) begin
    if (push_fire) begin
      t_var[wr_idx] <= push_var;
      t_val[wr_idx] <= push_val;
      t_lvl[wr_idx] <= push_lvl;
      t_dec[wr_idx] <= push_dec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      trail_cnt  <= '0;
      cur_level  <= '0;
      lvl_q      <= '0;
      cand_valid <= 1'b0;
      cand_var   <= '0;
      cand_val   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bt_req) begin
            lvl_q <= bt_level;
            state <= S_POP;
          end else if (push_fire) begin
            trail_cnt <= trail_cnt + LVL_W'(1);
            cur_level <= push_lvl;
          end
        end
        S_POP: begin
          if (pop_hit) begin
            trail_cnt <= trail_cnt - LVL_W'(1);
            // Pops run top-down, so the last decision seen is the lowest one.
            if (t_dec[top_idx]) begin
              cand_valid <= 1'b1;
              cand_var   <= t_var[top_idx];
              cand_val   <= t_val[top_idx];
            end
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          cur_level  <= (lvl_q < cur_level) ? lvl_q : cur_level;
          cand_valid <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BT_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bt_count <= '0;
    end else if (state == S_DONE && bt_count != '1) begin
      bt_count <= bt_count + 16'd1;
    end
  end
`endif

endmodule
